rs_syn_chk: RTL
===============

RS_SYN_CHK -- requirements
Module: rs_syn_chk

Interface
REQ-001 SHALL have parameter N, default 544, the codeword length in symbols.
REQ-002 SHALL have parameter NSYM, default 30, the number of parity symbols and syndromes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sop, input, 1 bit: marks the first symbol of a codeword; qualified by valid_in.
REQ-006 SHALL have port valid_in, input, 1 bit: data_in holds a received symbol this cycle.
REQ-007 SHALL have port data_in, input, 10 bits: received GF(2^10) symbol, highest-degree coefficient first.
REQ-008 SHALL have port ready, output, 1 bit: the block can accept symbols.
REQ-009 SHALL have port syn_valid, output, 1 bit: syn_idx/syn_data carry one syndrome.
REQ-010 SHALL have port syn_idx, output, 5 bits: syndrome index j, 0..NSYM-1.
REQ-011 SHALL have port syn_data, output, 10 bits: syndrome S_j.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of the syndrome dump.
REQ-013 SHALL have port frame_ok, output, 1 bit: all syndromes zero; valid only while frame_done=1.
REQ-014 SHALL have port sop_err, output, 1 bit: one-cycle pulse when sop aborts a partial frame.
REQ-015 SHALL have ports frames_total and frames_bad, outputs, 16 bits each: frame statistics (see Configuration).

Function
REQ-016 SHALL compute S_j = r(alpha^j), j=0..NSYM-1, over GF(2^10) with primitive polynomial x^10+x^3+1 and alpha=0x002, matching the encoder's generator roots alpha^0..alpha^29.
REQ-017 SHALL accumulate by Horner's rule: the first symbol loads S_j<=data_in; each later symbol applies S_j<=S_j*alpha^j xor data_in, using constant multipliers only.
REQ-018 SHALL use FSM states IDLE, ACC and DUMP.
REQ-019 IDLE: ready=1; a valid_in&sop symbol loads S_j, sets the symbol count to 1 and moves to ACC; valid_in without sop is ignored.
REQ-020 ACC: ready=1; valid_in=0 cycles stall with no state change; the symbol that makes count==N moves the FSM to DUMP.
REQ-021 ACC with valid_in&sop: SHALL pulse sop_err, restart accumulation with that symbol as symbol 1, and remain in ACC.
REQ-022 DUMP: ready=0 and inputs ignored; if the last symbol is accepted at cycle T, syn_valid=1 for cycles T+1..T+NSYM with syn_idx 0..NSYM-1 in order.
REQ-023 SHALL assert frame_done at cycle T+NSYM together with syndrome NSYM-1; frame_ok=1 iff all NSYM syndromes are zero.
REQ-024 SHALL return to IDLE at T+NSYM+1 with ready=1; a sop accepted at that cycle starts a new frame.
REQ-025 SHALL hold syn_valid, frame_done, frame_ok and sop_err at 0 when not asserted as above; syn_idx and syn_data SHALL be 0 when syn_valid=0.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, ready=1, clear all syndrome registers and counters, and drive every other output to 0, including mid-ACC or mid-DUMP.
REQ-027 A partial frame interrupted by reset SHALL be discarded with no frame_done.

Configuration
REQ-028 With macro RS_SYN_STATS_EN defined: frames_total SHALL increment at each frame_done, and frames_bad at each frame_done with frame_ok=0; both saturate at 0xFFFF.
REQ-029 Without RS_SYN_STATS_EN: frames_total and frames_bad SHALL be constant 0 and no counter logic is built.

Verification
REQ-030 544-symbol encoder output codeword, sop on symbol 0, valid_in continuous -> syndromes 0..29 all 0x000 on cycles T+1..T+30; frame_done=1 and frame_ok=1 at T+30.
REQ-031 Same codeword with the last symbol XORed by 0x005 -> every S_j=0x005, frame_ok=0.
REQ-032 Same codeword with valid_in low on every other cycle -> results identical to REQ-030; ready stays 1 during ACC.
REQ-033 sop reasserted at symbol 300, then a full clean codeword -> sop_err pulses once, one frame_done follows, frame_ok=1.
REQ-034 rst_n pulsed low at the 10th DUMP cycle -> syn_valid drops at once, no frame_done, ready=1; the next clean frame gives frame_ok=1.
REQ-035 With RS_SYN_STATS_EN: 3 clean frames plus 1 corrupted frame -> frames_total=4, frames_bad=1; without the macro both read 0.

Source files
------------

// File: rtl/rs_syn_chk.sv
`default_nettype none
// ============================================================================
// Module      : rs_syn_chk
// Description : Streaming RS(N, N-NSYM) syndrome checker over GF(2^10),
//               Horner accumulation with constant alpha^j multipliers,
//               followed by a serial syndrome dump and a frame_ok verdict.
//               Optional frame statistics built when RS_SYN_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_syn_chk #(
    parameter int N    = 544,
    parameter int NSYM = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sop,
    input  logic        valid_in,
    input  logic [9:0]  data_in,
    output logic        ready,
    output logic        syn_valid,
    output logic [4:0]  syn_idx,
    output logic [9:0]  syn_data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        sop_err,
    output logic [15:0] frames_total,
    output logic [15:0] frames_bad
);

    localparam int         c_CNT_W = $clog2(N + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACC   = 2'd1;
    localparam logic [1:0] c_DUMP  = 2'd2;

    // Multiply by alpha^p, p a compile-time constant: unrolls to an XOR network.
    function automatic logic [9:0] gf_mul_apow(input logic [9:0] a, input int p);
        logic [9:0] v;
        v = a;
        for (int k = 0; k < p; k++) begin
            v = {v[8:0], 1'b0} ^ (v[9] ? 10'h009 : 10'h000);
        end
        return v;
    endfunction

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_idx;
    logic               r_zero;
    logic               r_sop_err;
    logic [9:0]         r_syn    [NSYM];
    logic [9:0]         w_horner [NSYM];
    logic [9:0]         w_up     [NSYM];
    logic               w_load;
    logic               w_step;
    logic               w_dump;

    assign w_dump = (r_state == c_DUMP);
    assign w_load = valid_in && sop && (r_state == c_IDLE || r_state == c_ACC);
    assign w_step = valid_in && !sop && (r_state == c_ACC);

    // The dump shifts the syndrome bank down so S_idx always sits in r_syn[0].
    genvar j;
    generate
        for (j = 0; j < NSYM; j++) begin : g_syn
            assign w_horner[j] = gf_mul_apow(r_syn[j], j) ^ data_in;
            if (j == NSYM - 1) begin : g_top
                assign w_up[j] = 10'h000;
            end else begin : g_mid
                assign w_up[j] = r_syn[j+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSYM; k++) begin
                r_syn[k] <= 10'h000;
            end
        end else begin
            for (int k = 0; k < NSYM; k++) begin
                if (w_load) begin
                    r_syn[k] <= data_in;
                end else if (w_step) begin
                    r_syn[k] <= w_horner[k];
                end else if (w_dump) begin
                    r_syn[k] <= w_up[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_zero    <= 1'b1;
            r_sop_err <= 1'b0;
        end else begin
            r_sop_err <= valid_in && sop && (r_state == c_ACC);
            case (r_state)
                c_IDLE: begin
                    if (valid_in && sop) begin
                        r_cnt   <= c_CNT_W'(1);
                        r_state <= c_ACC;
                    end
                end
                c_ACC: begin
                    if (valid_in) begin
                        if (sop) begin
                            r_cnt <= c_CNT_W'(1);
                        end else if (r_cnt == c_CNT_W'(N - 1)) begin
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_zero  <= 1'b1;
                            r_state <= c_DUMP;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_DUMP: begin
                    r_zero <= r_zero && (r_syn[0] == 10'h000);
                    if (r_idx == 5'(NSYM - 1)) begin
                        r_idx   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign ready      = !w_dump;
    assign syn_valid  = w_dump;
    assign syn_idx    = w_dump ? r_idx : 5'd0;
    assign syn_data   = w_dump ? r_syn[0] : 10'h000;
    assign frame_done = w_dump && (r_idx == 5'(NSYM - 1));
    assign frame_ok   = frame_done && r_zero && (r_syn[0] == 10'h000);
    assign sop_err    = r_sop_err;

`ifdef RS_SYN_STATS_EN
    logic [15:0] r_frames_total;
    logic [15:0] r_frames_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frames_total <= 16'h0000;
            r_frames_bad   <= 16'h0000;
        end else if (frame_done) begin
            if (r_frames_total != 16'hFFFF) begin
                r_frames_total <= r_frames_total + 16'd1;
            end
            if (!frame_ok && r_frames_bad != 16'hFFFF) begin
                r_frames_bad <= r_frames_bad + 16'd1;
            end
        end
    end

    assign frames_total = r_frames_total;
    assign frames_bad   = r_frames_bad;
`else
    assign frames_total = 16'h0000;
    assign frames_bad   = 16'h0000;
`endif

endmodule
`default_nettype wire
